// File: rtl/mem_addr_pkg.sv
// Shared types and default widths for the burst address sequencer.
// Page-wrap mode is selected by the MEM_ADDR_SEQ_PAGE_WRAP_EN macro in mem_addr_seq.
package mem_addr_pkg;

  localparam int DEF_AW    = 16;
  localparam int DEF_NSRC  = 4;
  localparam int DEF_LENW  = 4;
  localparam int DEF_PAGEW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/mem_addr_mux.sv
// NSRC:1 address selector; a disabled or out-of-range select yields zero.
module mem_addr_mux
  import mem_addr_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int NSRC = DEF_NSRC,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC*AW-1:0] src_i,
  input  logic               en_i,
  input  logic [SELW-1:0]    sel_i,
  output logic [AW-1:0]      addr_o
);

  always_comb begin
    // NOTE: default assignment first, so no path leaves addr_o unassigned and no latch is inferred.
    addr_o = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (en_i && (int'(sel_i) == k)) begin
        addr_o = src_i[k*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/mem_addr_seq.sv
// Burst address sequencer: captures a selected base address and emits LEN+1 beats with valid/ready.
// Define MEM_ADDR_SEQ_PAGE_WRAP_EN to confine the per-beat step to the low PAGEW address bits.
module mem_addr_seq
  import mem_addr_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int NSRC  = DEF_NSRC,
  parameter int SELW  = $clog2(NSRC),
  parameter int LENW  = DEF_LENW,
  parameter int PAGEW = DEF_PAGEW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NSRC*AW-1:0] SRC_BUS,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_EN,
  input  logic [SELW-1:0]    REQ_SEL,
  input  logic               REQ_DIR,
  input  logic [LENW-1:0]    REQ_LEN,
  output logic               ADDR_VALID,
  input  logic               ADDR_READY,
  output logic [AW-1:0]      ADDR,
  output logic               ADDR_LAST,
  output logic               BUSY
);

  if (PAGEW < 1 || PAGEW >= AW) begin : g_pagew_check
    $error("mem_addr_seq: PAGEW must lie in [1, AW-1]");
  end

  state_e          state_q;
  logic [AW-1:0]   addr_q, addr_d, base_d;
  logic [LENW-1:0] cnt_q, cnt_d, len_q;
  logic            dir_q, valid_q, last_q;

  mem_addr_mux #(
    .AW   (AW),
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_base_mux (
    .src_i  (SRC_BUS),
    .en_i   (REQ_EN),
    .sel_i  (REQ_SEL),
    .addr_o (base_d)
  );

  // Address of the following beat; page mode keeps the upper bits of the base.
  always_comb begin
    addr_d = addr_q;
`ifdef MEM_ADDR_SEQ_PAGE_WRAP_EN
    case (dir_q)
      DIR_INC: addr_d[PAGEW-1:0] = addr_q[PAGEW-1:0] + PAGEW'(1);
      DIR_DEC: addr_d[PAGEW-1:0] = addr_q[PAGEW-1:0] - PAGEW'(1);
    endcase
`else
    case (dir_q)
      DIR_INC: addr_d = addr_q + AW'(1);
      DIR_DEC: addr_d = addr_q - AW'(1);
    endcase
`endif
  end

  assign cnt_d = cnt_q + LENW'(1);

  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= DIR_INC;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ_VALID) begin
            state_q <= BURST;
            addr_q  <= base_d;
            cnt_q   <= '0;
            len_q   <= REQ_LEN;
            dir_q   <= REQ_DIR;
            valid_q <= 1'b1;
            last_q  <= (REQ_LEN == '0);
          end
        end
        BURST: begin
          if (ADDR_READY) begin
            if (cnt_q == len_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              addr_q <= addr_d;
              cnt_q  <= cnt_d;
              last_q <= (cnt_d == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY  = (state_q == IDLE);
  assign BUSY       = (state_q == BURST);
  assign ADDR_VALID = valid_q;
  assign ADDR       = addr_q;
  assign ADDR_LAST  = last_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Scoreboard bench for mem_addr_seq: directed bursts push expected beats; a monitor checks handshakes.
module tb_mem_addr_seq;

  typedef struct packed {
    logic [15:0] addr;
    logic        last;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] SRC_BUS;
  logic        REQ_VALID, REQ_READY, REQ_EN, REQ_DIR;
  logic [1:0]  REQ_SEL;
  logic [3:0]  REQ_LEN;
  logic        ADDR_VALID, ADDR_READY, ADDR_LAST, BUSY;
  logic [15:0] ADDR;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t sb[$];
  beat_t prev_beat;
  logic  stalled = 1'b0;

  mem_addr_seq dut (
    .CLK        (CLK),
    .RST        (RST),
    .SRC_BUS    (SRC_BUS),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_EN     (REQ_EN),
    .REQ_SEL    (REQ_SEL),
    .REQ_DIR    (REQ_DIR),
    .REQ_LEN    (REQ_LEN),
    .ADDR_VALID (ADDR_VALID),
    .ADDR_READY (ADDR_READY),
    .ADDR       (ADDR),
    .ADDR_LAST  (ADDR_LAST),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [15:0] a, input logic l);
    beat_t b;
    b.addr = a;
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic set_src(input int k, input logic [15:0] v);
    SRC_BUS[k*16 +: 16] = v;
  endtask

  // Waits for REQ_READY (bounded), then presents one request for one edge.
  task automatic issue(input logic en, input logic [1:0] sel, input logic dir, input logic [3:0] len);
    int n = 0;
    while (!REQ_READY && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!REQ_READY) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_timeout: REQ_READY still %b after %0d cycles, expected 1", REQ_READY, n);
    end
    REQ_VALID = 1'b1;
    REQ_EN    = en;
    REQ_SEL   = sel;
    REQ_DIR   = dir;
    REQ_LEN   = len;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // Waits until every expected beat has been consumed and the block is idle again.
  task automatic drain(input string name, input logic [15:0] final_addr);
    int n = 0;
    while (!(sb.size() == 0 && REQ_READY) && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check({name, "_drained"}, {31'd0, (sb.size() == 0 && REQ_READY)}, 32'd1);
    check({name, "_idle_valid"}, {31'd0, ADDR_VALID}, 32'd0);
    check({name, "_idle_last"}, {31'd0, ADDR_LAST}, 32'd0);
    check({name, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
    check({name, "_idle_addr_hold"}, {16'd0, ADDR}, {16'd0, final_addr});
    sb.delete();
  endtask

  // Monitor: compares each presented beat on handshake and enforces the hold rule while stalled.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        stalled = 1'b0;
      end else if (ADDR_VALID) begin
        if (stalled) begin
          check("hold_addr", {16'd0, ADDR}, {16'd0, prev_beat.addr});
          check("hold_last", {31'd0, ADDR_LAST}, {31'd0, prev_beat.last});
        end
        if (ADDR_READY) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got addr %h last %b, expected no beat", ADDR, ADDR_LAST);
          end else begin
            beat_t e;
            e = sb.pop_front();
            check("beat_addr", {16'd0, ADDR}, {16'd0, e.addr});
            check("beat_last", {31'd0, ADDR_LAST}, {31'd0, e.last});
          end
          stalled = 1'b0;
        end else begin
          stalled        = 1'b1;
          prev_beat.addr = ADDR;
          prev_beat.last = ADDR_LAST;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST        = 1'b1;
    SRC_BUS    = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    REQ_VALID  = 1'b0;
    REQ_EN     = 1'b0;
    REQ_SEL    = '0;
    REQ_DIR    = 1'b0;
    REQ_LEN    = '0;
    ADDR_READY = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", {31'd0, REQ_READY}, 32'd1);
    check("rst_addr_valid", {31'd0, ADDR_VALID}, 32'd0);
    check("rst_addr", {16'd0, ADDR}, 32'h0000);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_last", {31'd0, ADDR_LAST}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Select source 2, increment 4 beats; request held while busy must be ignored.
    expect_beat(16'h3000, 1'b0);
    expect_beat(16'h3001, 1'b0);
    expect_beat(16'h3002, 1'b0);
    expect_beat(16'h3003, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 4'd3);
    set_src(2, 16'hDEAD);
    check("t1_first_addr", {16'd0, ADDR}, 32'h3000);
    check("t1_busy", {31'd0, BUSY}, 32'd1);
    REQ_VALID = 1'b1;
    REQ_SEL   = 2'd0;
    REQ_LEN   = 4'd0;
    check("t1_ready_while_busy", {31'd0, REQ_READY}, 32'd0);
    @(posedge CLK); #1;
    check("t1_ready_while_busy2", {31'd0, REQ_READY}, 32'd0);
    REQ_VALID = 1'b0;
    drain("t1", 16'h3003);
    set_src(2, 16'h3000);

    // Zero base, decrement 2 beats across the zero boundary.
    expect_beat(16'h0000, 1'b0);
`ifdef MEM_ADDR_SEQ_PAGE_WRAP_EN
    expect_beat(16'h00FF, 1'b1);
    issue(1'b0, 2'd2, 1'b1, 4'd1);
    drain("t2", 16'h00FF);
`else
    expect_beat(16'hFFFF, 1'b1);
    issue(1'b0, 2'd2, 1'b1, 4'd1);
    drain("t2", 16'hFFFF);
`endif

    // Backpressure: beat 1 stalled for three cycles.
    expect_beat(16'h1000, 1'b0);
    expect_beat(16'h1001, 1'b0);
    expect_beat(16'h1002, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 4'd2);
    @(posedge CLK); #1;
    ADDR_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("t3_stalled_addr", {16'd0, ADDR}, 32'h1001);
    ADDR_READY = 1'b1;
    drain("t3", 16'h1002);

    // Single beat: ADDR_LAST immediately; a waiting request is not taken during the final beat.
    expect_beat(16'h2000, 1'b1);
    expect_beat(16'h4000, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 4'd0);
    check("t4_last_now", {31'd0, ADDR_LAST}, 32'd1);
    check("t4_not_ready", {31'd0, REQ_READY}, 32'd0);
    REQ_VALID = 1'b1;
    REQ_SEL   = 2'd3;
    REQ_LEN   = 4'd0;
    @(posedge CLK); #1;
    check("t4_gap_valid", {31'd0, ADDR_VALID}, 32'd0);
    check("t4_gap_ready", {31'd0, REQ_READY}, 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    check("t4_second_addr", {16'd0, ADDR}, 32'h4000);
    drain("t4", 16'h4000);

    // Reset during beat 2 of an 8-beat burst, then a clean restart.
    expect_beat(16'h4000, 1'b0);
    expect_beat(16'h4001, 1'b0);
    issue(1'b1, 2'd3, 1'b0, 4'd7);
    @(posedge CLK);
    @(posedge CLK); #1;
    check("t5_beat2_addr", {16'd0, ADDR}, 32'h4002);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("t5_rst_valid", {31'd0, ADDR_VALID}, 32'd0);
    check("t5_rst_ready", {31'd0, REQ_READY}, 32'd1);
    check("t5_rst_busy", {31'd0, BUSY}, 32'd0);
    check("t5_rst_addr", {16'd0, ADDR}, 32'h0000);
    check("t5_rst_leftover", sb.size(), 32'd0);
    sb.delete();
    expect_beat(16'h2000, 1'b0);
    expect_beat(16'h2001, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 4'd1);
    drain("t5", 16'h2001);

    // Page boundary behaviour, increment and decrement, plus top-of-space wrap.
    set_src(0, 16'h12FE);
    set_src(1, 16'h1300);
    set_src(3, 16'hFFFE);
    expect_beat(16'h12FE, 1'b0);
    expect_beat(16'h12FF, 1'b0);
`ifdef MEM_ADDR_SEQ_PAGE_WRAP_EN
    expect_beat(16'h1200, 1'b0);
    expect_beat(16'h1201, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 4'd3);
    drain("t6_inc", 16'h1201);
    expect_beat(16'h1300, 1'b0);
    expect_beat(16'h13FF, 1'b1);
    issue(1'b1, 2'd1, 1'b1, 4'd1);
    drain("t6_dec", 16'h13FF);
    expect_beat(16'hFFFE, 1'b0);
    expect_beat(16'hFFFF, 1'b0);
    expect_beat(16'hFF00, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 4'd2);
    drain("t6_top", 16'hFF00);
`else
    expect_beat(16'h1300, 1'b0);
    expect_beat(16'h1301, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 4'd3);
    drain("t6_inc", 16'h1301);
    expect_beat(16'h1300, 1'b0);
    expect_beat(16'h12FF, 1'b1);
    issue(1'b1, 2'd1, 1'b1, 4'd1);
    drain("t6_dec", 16'h12FF);
    expect_beat(16'hFFFE, 1'b0);
    expect_beat(16'hFFFF, 1'b0);
    expect_beat(16'h0000, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 4'd2);
    drain("t6_top", 16'h0000);
`endif

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_addr_seq.md
Name: mem_addr_seq

Overview:
- Parametrised successor to the memory-read address bus selector.
- Selects one of NSRC address sources, or zero, as a burst base address and registers it.
- Emits a burst of sequential addresses: incrementing or decrementing, with a valid/ready handshake on both the request and address sides.
- Sits between instruction decode/index registers and the memory read port.

Parameters:
- AW, 16, address width in bits.
- NSRC, 4, number of address sources (≥2).
- SELW, $clog2(NSRC), width of the source-select field.
- LENW, 4, burst length field width; a burst is REQ_LEN+1 beats.
- PAGEW, 8, page offset width; used only with the optional feature, AW > PAGEW.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- SRC_BUS  in  NSRC*AW  flattened sources; source k is at bits [k*AW +: AW].
- REQ_VALID  in  1  burst request present.
- REQ_READY  out  1  block can accept a request.
- REQ_EN  in  1  1 = use selected source; 0 = base address forced to zero.
- REQ_SEL  in  SELW  source index.
- REQ_DIR  in  1  0 = +1 per beat, 1 = −1 per beat.
- REQ_LEN  in  LENW  beats minus one.
- ADDR_VALID  out  1  ADDR holds a valid beat.
- ADDR_READY  in  1  consumer accepts the beat.
- ADDR  out  AW  current address.
- ADDR_LAST  out  1  current beat is the final beat of the burst.
- BUSY  out  1  burst in progress.

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST).
- Reset values: state=IDLE, REQ_READY=1, ADDR_VALID=0, ADDR=0, ADDR_LAST=0, BUSY=0, beat counter=0.
- States: IDLE, BURST.
- REQ_READY is 1 only in IDLE. BUSY is 1 only in BURST.
- IDLE, when REQ_VALID & REQ_READY:
  - Capture base: SRC_BUS[REQ_SEL] if REQ_EN=1 and REQ_SEL<NSRC, else zero.
  - Capture REQ_DIR and REQ_LEN. Clear the beat counter.
  - Go to BURST.
- Latency: a request accepted on edge N makes ADDR_VALID=1 after edge N, with ADDR=base.
- BURST, ADDR_VALID=1 throughout.
  - On ADDR_READY=1 with counter≠len: ADDR ← ADDR±1, counter+1.
  - On ADDR_READY=1 with counter=len: the final handshake completes. Go to IDLE, ADDR_VALID←0, ADDR_LAST←0.
- ADDR_LAST=1 exactly while ADDR_VALID=1 and counter=len. REQ_LEN=0 gives a single beat with ADDR_LAST=1 immediately.
- Hold rule: while ADDR_VALID=1 and ADDR_READY=0, ADDR and ADDR_LAST hold stable.
- ADDR holds its last value in IDLE. It is not cleared.
- Arithmetic: ±1 is modulo 2^AW. 0xFFFF+1=0x0000 and 0x0000−1=0xFFFF at AW=16.
- No request is accepted during the final beat. The minimum gap between bursts is one IDLE cycle.
- Source changes on SRC_BUS after capture do not affect the burst in progress.
- RST asserted mid-burst: return to reset values on that edge. The remaining beats are discarded.
- REQ_VALID asserted while BUSY: ignored, left pending. REQ_READY=0.

Optional Feature:
- Macro: MEM_ADDR_SEQ_PAGE_WRAP_EN.
- Defined: the increment/decrement affects only ADDR[PAGEW-1:0], wrapping within the page. ADDR[AW-1:PAGEW] holds the base's upper bits, e.g. 0x12FF+1 → 0x1200.
- Undefined: full AW-bit wrap as above, e.g. 0x12FF+1 → 0x1300.

Decomposition:
- Package mem_addr_pkg:
  - state enum {IDLE, BURST}.
  - DIR_INC=1'b0, DIR_DEC=1'b1.
  - Default width localparams.
- Sub-module mem_addr_mux: combinational NSRC:1 AW-bit selector with enable and out-of-range-to-zero, used for base selection.

Test Plan:
- Reset: assert RST 2 cycles → REQ_READY=1, ADDR_VALID=0, ADDR=0x0000, BUSY=0.
- Select and increment:
  - Stimulus: SRC_BUS sources = {0x4000, 0x3000, 0x2000, 0x1000}, REQ_EN=1, SEL=2, DIR=0, LEN=3, ADDR_READY=1.
  - Response: ADDR 0x3000, 0x3001, 0x3002, 0x3003 on consecutive cycles; ADDR_LAST only on 0x3003; then IDLE.
- Zero select and wrap:
  - Stimulus: REQ_EN=0, DIR=1, LEN=1.
  - Response: ADDR 0x0000 then 0xFFFF, ADDR_LAST on the second beat.
- Backpressure:
  - Stimulus: LEN=2, base 0x1000, ADDR_READY low for 3 cycles on beat 1.
  - Response: ADDR holds 0x1001 stable until accepted; the burst completes with 3 beats total.
- Reset mid-burst: RST on beat 2 of a LEN=7 burst → next cycle ADDR_VALID=0, REQ_READY=1; a new request starts cleanly from its base.
- Page wrap (macro defined): base 0x12FE, DIR=0, LEN=3 → ADDR 0x12FE, 0x12FF, 0x1200, 0x1201. Without the macro: 0x12FE, 0x12FF, 0x1300, 0x1301.
